// File: rtl/z_m_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encodings,
// default widths and the slice-counter width helper.
package z_adder_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_N = 16;
  localparam int DEFAULT_M = 4;

  // Counter must hold values 0..k-1; never narrower than one bit.
  function automatic int cnt_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/z_m_sca_stage.sv
// Combinational M-bit ripple slice adder used once per cycle by the
// digit-serial adder.
module z_m_sca_stage #(
  parameter int M = 4
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         c_in,
  output logic [M-1:0] sum,
  output logic         c_out
);

  logic [M:0] carry;

  assign carry[0] = c_in;

  for (genvar gi = 0; gi < M; gi++) begin : g_bit
    assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
  end

  assign c_out = carry[M];

endmodule

// File: rtl/z_m_serial_adder.sv
// Digit-serial N-bit adder processing M bits per clock, LSB slice first.
// Define Z_M_SERIAL_OVF_EN to add the signed-overflow output ovf.
module z_m_serial_adder
  import z_adder_defs::*;
#(
  parameter int N = DEFAULT_N,
  parameter int M = DEFAULT_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out
`ifdef Z_M_SERIAL_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int K  = N / M;
  localparam int CW = cnt_width(K);

  if (M < 1 || (N % M) != 0) begin : g_bad_params
    $error("z_m_serial_adder: N (%0d) must be a positive multiple of M (%0d)", N, M);
  end

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [N-1:0]    a_sh_reg, b_sh_reg;
  logic            carry_reg;
  logic [N-1:0]    sum_reg;
  logic            c_out_reg;

  logic [M-1:0]    slice_sum;
  logic            slice_carry;
  logic            last_slice;
  logic [N-1:0]    sum_shifted;

  z_m_sca_stage #(.M(M)) u_stage (
    .a     (a_sh_reg[M-1:0]),
    .b     (b_sh_reg[M-1:0]),
    .c_in  (carry_reg),
    .sum   (slice_sum),
    .c_out (slice_carry)
  );

  assign last_slice = (count_reg == CW'(K - 1));

  // New slice enters at the top so the result is aligned after K shifts.
  if (K == 1) begin : g_single
    assign sum_shifted = slice_sum;
  end else begin : g_multi
    assign sum_shifted = {slice_sum, sum_reg[N-1:M]};
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= c_in;
            count_reg <= '0;
          end
        end
        RUN: begin
          a_sh_reg  <= a_sh_reg >> M;
          b_sh_reg  <= b_sh_reg >> M;
          sum_reg   <= sum_shifted;
          carry_reg <= slice_carry;
          count_reg <= count_reg + CW'(1);
          if (last_slice) c_out_reg <= slice_carry;
        end
        default: ;
      endcase
    end
  end

`ifdef Z_M_SERIAL_OVF_EN
  logic a_msb_reg, b_msb_reg, ovf_reg;

  // The final slice's top bit is the result MSB, so overflow resolves on the last edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      a_msb_reg <= a[N-1];
      b_msb_reg <= b[N-1];
    end else if (state_reg == RUN && last_slice) begin
      ovf_reg <= (a_msb_reg == b_msb_reg) && (slice_sum[M-1] != a_msb_reg);
    end
  end

  assign ovf = ovf_reg;
`endif

  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == DONE);
  assign sum   = sum_reg;
  assign c_out = c_out_reg;

endmodule

// File: doc/z_m_serial_adder.md
Name: z_m_serial_adder

Overview:
- Digit-serial N-bit adder. Adds M bits per clock by driving one M-bit slice adder (z_m_sca_stage) with successive operand slices, LSB slice first.
- The carry out of each slice is registered and fed back as the carry in of the next slice.
- Sits where a full-width adder is too large. It feeds z_m_sca_stage and consumes its sum and carry outputs.

Parameters:
- N, 16, operand and result width. Must be an integer multiple of M; any other value must fail elaboration.
- M, 4, slice width per cycle, passed to z_m_sca_stage.
- K (localparam), N/M, number of slice cycles.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset. Synchronous, active-high.
- start, input, 1, request. Sampled only while busy is 0.
- a, input, N, operand A. Captured on the edge that accepts start.
- b, input, N, operand B. Captured on the edge that accepts start.
- c_in, input, 1, initial carry. Captured on the edge that accepts start.
- busy, output, 1, high while an operation is in progress (state not IDLE).
- done, output, 1, one-cycle pulse: result is valid.
- sum, output, N, registered result.
- c_out, output, 1, registered final carry.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state to IDLE; count, operand shift registers, carry register, sum and c_out to 0; busy and done to 0.
  - rst overrides all other inputs.
  - Reset during RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE. State is registered. busy = (state != IDLE); done = (state == DONE).
- IDLE:
  - start=1 loads a and b into shift registers, c_in into the carry register, and 0 into count; next state is RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Slice operands are the low M bits of each shift register; carry in is the carry register.
  - Both operand registers shift right by M.
  - sum register becomes {slice_sum, sum[N-1:M]}, so the result assembles from the top.
  - Carry register takes the slice carry out; count increments.
  - When count == K-1 at the edge: c_out takes the slice carry out and next state is DONE.
- DONE: done=1 for exactly one cycle; next state is IDLE unconditionally.
- start while busy=1 (RUN or DONE) is ignored; operands are not re-sampled.
- Latency: start accepted at edge E0 → done high in the cycle following edge E0+K. Minimum issue interval is K+2 cycles.
- sum and c_out hold their values from DONE until the next accepted start; they do not change during IDLE.
- Wrap-around: the sum is modulo 2^N; the carry out of the top slice appears only on c_out.
- K=1 (N==M) is legal: one RUN cycle.

Optional Feature:
- Macro Z_M_SERIAL_OVF_EN.
- Defined:
  - Adds output port ovf, 1 bit: signed two's-complement overflow.
  - Latched operand MSBs a[N-1] and b[N-1] are held for the whole operation.
  - ovf = (aMSB == bMSB) && (sum[N-1] != aMSB). Registered, valid from DONE, held like sum, reset to 0.
- Undefined: port ovf and its registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package/include (z_adder_defs): state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; default N and M; the counter-width function (clog2 of K, minimum 1).
- One sub-module instance, z_m_sca_stage #(M), as the combinational slice adder.
- Control FSM, counter and shift registers live in this module.

Test Plan (N=16, M=4):
- a=0x1234, b=0x4321, c_in=0 → sum=0x5555, c_out=0; done exactly 4 edges after the accepting edge; busy high for 5 cycles.
- a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1. Checks carry propagation across all slices.
- a=0x00FF, b=0x0001, c_in=1 → sum=0x0101, c_out=0. Checks the initial carry path.
- start with a=0x1111, b=0x1111, then start with a=0xFFFF during RUN → the second request is ignored; sum=0x2222. A new start accepted in IDLE produces a fresh result.
- rst asserted at the 2nd RUN edge → busy=0, done never pulses, sum=0, c_out=0. A following operation computes correctly.
- With Z_M_SERIAL_OVF_EN: 0x7FFF+0x0001 → sum=0x8000, ovf=1. 0xFFFF+0x0001 → ovf=0, c_out=1.
